// File: rtl/rf_pkg.sv
// Shared constants for the integer register file.
// Decode, writeback and the register file all use these defaults, so the
// address width and the hardwired-zero register index are defined only here.
//   XLEN_DEFAULT  : default data width in bits
//   NREGS_DEFAULT : default number of architectural registers
//   REG_ZERO      : index of the hardwired zero register (x0)
//   addr_width()  : register address width for a given register count
package rf_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned REG_ZERO      = 0;

    // A lone register would still need a 1-bit address field.
    function automatic int unsigned addr_width(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard.
// Decode marks the destination of an issued instruction busy; a writeback to
// that register clears it. When issue and writeback hit the same register in
// one cycle, the issue wins because the newly issued instruction now owns it.
// Ports:
//   clk, reset   : rising-edge clock, asynchronous active-high clear
//   we, wb_addr  : writeback enables and packed addresses (port k at [k*AW +: AW])
//   issue_en     : mark issue_addr busy at the next edge
//   issue_addr   : destination of the issued instruction
//   rd_addr      : packed read-port addresses (port j at [j*AW +: AW])
//   rd_mask      : per read port, suppress busy (a same-cycle bypass supplies the data)
//   rd_busy      : per read port, 1 = register has a pending write
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1,
    parameter int unsigned AW    = addr_width(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] wb_addr,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    rd_mask,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clears first, then the issue set, so a same-cycle issue overrides a clear.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NWR; k++) begin
            if (we[k]) begin
                busy_d[wb_addr[k*AW +: AW]] = 1'b0;
            end
        end
        if (issue_en) begin
            busy_d[issue_addr] = 1'b1;
        end
        // x0 never has a producer.
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_lookup
        assign rd_busy[j] = ~reset & ~rd_mask[j] & busy_q[rd_addr[j*AW +: AW]];
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port integer register file with a pending-write scoreboard.
// Sits between decode (reads, issue) and writeback (writes). x0 reads as zero
// and ignores writes and issues. Reads are combinational; with BYPASS set, a
// read of a register being written this cycle returns the incoming data.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-high clear of all registers and busy bits
//   we         : per write port enable
//   wb_addr    : packed write addresses, port k at [k*AW +: AW]
//   wb_data    : packed write data, port k at [k*XLEN +: XLEN]
//   rd_addr    : packed read addresses, port j at [j*AW +: AW]
//   rd_data    : packed read data, port j at [j*XLEN +: XLEN] (combinational)
//   rd_busy    : per read port, 1 = addressed register has a pending write
//   issue_en   : mark issue_addr pending at the next edge
//   issue_addr : destination register of the issued instruction
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned NREGS  = NREGS_DEFAULT,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 1,
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned AW     = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wb_addr,
    input  logic [NWR*XLEN-1:0] wb_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NRD-1:0]  byp_hit;

    // Write decode: ports scanned in ascending order so the highest index wins
    // an address conflict. Entry 0 is pinned to zero and folds away in synthesis.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && (wb_addr[k*AW +: AW] == AW'(i))) begin
                    regs_d[i] = wb_data[k*XLEN +: XLEN];
                end
            end
        end
        regs_d[REG_ZERO] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            hit;

        assign addr = rd_addr[j*AW +: AW];

        always_comb begin
            data = regs_q[addr];
            hit  = 1'b0;
            if (BYPASS) begin
                for (int k = 0; k < NWR; k++) begin
                    if (we[k] && (wb_addr[k*AW +: AW] == addr)) begin
                        data = wb_data[k*XLEN +: XLEN];
                        hit  = 1'b1;
                    end
                end
            end
            // x0 and a held reset both force a clean zero, even against a bypass.
            if ((addr == AW'(REG_ZERO)) || reset) begin
                data = '0;
                hit  = 1'b0;
            end
        end

        assign rd_data[j*XLEN +: XLEN] = data;
        assign byp_hit[j]              = hit;
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .wb_addr    (wb_addr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .rd_addr    (rd_addr),
        .rd_mask    (byp_hit),
        .rd_busy    (rd_busy)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a two-write-port bypassing instance and a
// single-write-port non-bypassing instance sharing read/issue stimulus,
// followed by a randomised phase against a small reference model.
module tb_reg_file_mp;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic          clk;
    logic          reset;
    logic [1:0]    we;
    logic [2*AW-1:0]   wb_addr;
    logic [2*XLEN-1:0] wb_data;
    logic [2*AW-1:0]   rd_addr;
    logic [2*XLEN-1:0] rd_data;
    logic [1:0]        rd_busy;
    logic [2*XLEN-1:0] nb_rd_data;
    logic [1:0]        nb_rd_busy;
    logic              issue_en;
    logic [AW-1:0]     issue_addr;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic [31:0] exp_d;
    logic        exp_b;

    reg_file_mp #(
        .XLEN   (XLEN),
        .NREGS  (32),
        .NRD    (2),
        .NWR    (2),
        .BYPASS (1'b1)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .issue_en   (issue_en),
        .issue_addr (issue_addr)
    );

    // Write port 0 only, no bypass.
    reg_file_mp #(
        .XLEN   (XLEN),
        .NREGS  (32),
        .NRD    (2),
        .NWR    (1),
        .BYPASS (1'b0)
    ) u_dut_nb (
        .clk        (clk),
        .reset      (reset),
        .we         (we[0:0]),
        .wb_addr    (wb_addr[AW-1:0]),
        .wb_data    (wb_data[XLEN-1:0]),
        .rd_addr    (rd_addr),
        .rd_data    (nb_rd_data),
        .rd_busy    (nb_rd_busy),
        .issue_en   (issue_en),
        .issue_addr (issue_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input int k, input logic en, input logic [AW-1:0] a,
                          input logic [31:0] d);
        we[k]                 = en;
        wb_addr[k*AW +: AW]   = a;
        wb_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int j, input logic [AW-1:0] a);
        rd_addr[j*AW +: AW] = a;
    endtask

    function automatic logic [31:0] rd(input int j);
        return rd_data[j*XLEN +: XLEN];
    endfunction

    function automatic logic [31:0] nb_rd(input int j);
        return nb_rd_data[j*XLEN +: XLEN];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; we = '0; wb_addr = '0; wb_data = '0; rd_addr = '0;
        issue_en = 1'b0; issue_addr = '0;
        #2;
        chk("rst_rd0", rd(0), 32'h0);
        chk("rst_busy", {30'd0, rd_busy}, 32'h0);

        // Write request while reset is held must not leak through the bypass.
        set_wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        set_rd(0, 5'd5);
        #1;
        chk("rst_hold_bypass", rd(0), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("x5_bypass", rd(0), 32'hDEAD_BEEF);
        tick();
        we = '0;
        #1;
        chk("x5_stored", rd(0), 32'hDEAD_BEEF);
        chk("x5_stored_nb", nb_rd(0), 32'hDEAD_BEEF);

        // Mid-cycle reset clears immediately.
        reset = 1'b1;
        #1;
        chk("rst_mid", rd(0), 32'h0);
        chk("rst_mid_nb", nb_rd(0), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_after", rd(0), 32'h0);
        chk("rst_after_busy", {30'd0, rd_busy}, 32'h0);

        // x0: write and issue are both dropped.
        set_wr(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        issue_en = 1'b1; issue_addr = 5'd0;
        set_rd(0, 5'd0);
        #1;
        chk("x0_same", rd(0), 32'h0);
        chk("x0_same_busy", {31'd0, rd_busy[0]}, 32'h0);
        tick();
        we = '0; issue_en = 1'b0;
        #1;
        chk("x0_next", rd(0), 32'h0);
        chk("x0_next_busy", {31'd0, rd_busy[0]}, 32'h0);

        // Bypass vs. no bypass on x7.
        set_wr(0, 1'b1, 5'd7, 32'h1234);
        set_rd(0, 5'd7);
        #1;
        chk("byp_same", rd(0), 32'h1234);
        chk("nobyp_same", nb_rd(0), 32'h0);
        tick();
        we = '0;
        #1;
        chk("byp_next", rd(0), 32'h1234);
        chk("nobyp_next", nb_rd(0), 32'h1234);
        chk("x7_not_busy", {31'd0, rd_busy[0]}, 32'h0);

        // Scoreboard: issue x3, then write it back.
        set_rd(1, 5'd3);
        issue_en = 1'b1; issue_addr = 5'd3;
        #1;
        chk("sb_pre_issue", {31'd0, rd_busy[1]}, 32'h0);
        tick();
        issue_en = 1'b0;
        #1;
        chk("sb_busy", {31'd0, rd_busy[1]}, 32'h1);
        chk("sb_busy_nb", {31'd0, nb_rd_busy[1]}, 32'h1);
        set_wr(0, 1'b1, 5'd3, 32'h55);
        #1;
        chk("sb_wb_byp_busy", {31'd0, rd_busy[1]}, 32'h0);
        chk("sb_wb_byp_data", rd(1), 32'h55);
        chk("sb_wb_nb_busy", {31'd0, nb_rd_busy[1]}, 32'h1);
        chk("sb_wb_nb_data", nb_rd(1), 32'h0);
        tick();
        we = '0;
        #1;
        chk("sb_clr_busy", {31'd0, rd_busy[1]}, 32'h0);
        chk("sb_clr_busy_nb", {31'd0, nb_rd_busy[1]}, 32'h0);
        chk("sb_clr_data", rd(1), 32'h55);

        // Same-cycle issue and write to x3: busy set wins, data still written.
        issue_en = 1'b1; issue_addr = 5'd3;
        set_wr(0, 1'b1, 5'd3, 32'h66);
        tick();
        issue_en = 1'b0; we = '0;
        #1;
        chk("iw_busy", {31'd0, rd_busy[1]}, 32'h1);
        chk("iw_data", rd(1), 32'h66);
        chk("iw_busy_nb", {31'd0, nb_rd_busy[1]}, 32'h1);
        chk("iw_data_nb", nb_rd(1), 32'h66);

        // Two-port conflict on x9: port 1 wins.
        set_wr(0, 1'b1, 5'd9, 32'hA);
        set_wr(1, 1'b1, 5'd9, 32'hB);
        set_rd(0, 5'd9);
        set_rd(1, 5'd9);
        #1;
        chk("conf_byp", rd(0), 32'hB);
        tick();
        we = '0;
        #1;
        chk("conf_rd0", rd(0), 32'hB);
        chk("conf_rd1", rd(1), 32'hB);
        chk("conf_nb", nb_rd(0), 32'hA);

        // Randomised phase against a reference model.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 2; k++) begin
                set_wr(k, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                   : 5'($urandom_range(0, 7)),
                       $urandom);
            end
            for (int j = 0; j < 2; j++) set_rd(j, 5'($urandom_range(0, 7)));
            issue_en   = 1'($urandom_range(0, 1));
            issue_addr = 5'($urandom_range(0, 7));
            #2;
            for (int j = 0; j < 2; j++) begin
                logic [AW-1:0] a;
                a = rd_addr[j*AW +: AW];
                exp_d = m_regs[a];
                exp_b = m_busy[a];
                for (int k = 0; k < 2; k++) begin
                    if (we[k] && wb_addr[k*AW +: AW] == a) begin
                        exp_d = wb_data[k*XLEN +: XLEN];
                        exp_b = 1'b0;
                    end
                end
                if (a == 5'd0) begin
                    exp_d = '0;
                    exp_b = 1'b0;
                end
                chk("rand_data", rd(j), exp_d);
                chk("rand_busy", {31'd0, rd_busy[j]}, {31'd0, exp_b});
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (we[k] && wb_addr[k*AW +: AW] != 5'd0) begin
                    m_regs[wb_addr[k*AW +: AW]] = wb_data[k*XLEN +: XLEN];
                    m_busy[wb_addr[k*AW +: AW]] = 1'b0;
                end
            end
            if (issue_en && issue_addr != 5'd0) m_busy[issue_addr] = 1'b1;
            #1;
        end

        we = '0; issue_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
